// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default bit-time width
// and frame-length limits used by the receive sequencer and its bit timer.
package uart_pkg;

    localparam int BTC_W_DEF = 19;
    localparam int NBITS_MIN = 8;
    localparam int NBITS_MAX = 10;
    localparam int BITCNT_W  = $clog2(NBITS_MAX + 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_BREAK = 2'd3
    } rx_state_t;

    // Bits shifted after the start bit: data bits, optional parity, then stop.
    function automatic logic [BITCNT_W-1:0] frameBits(input logic eight, input logic pen);
        frameBits = BITCNT_W'(NBITS_MIN) + BITCNT_W'(eight) + BITCNT_W'(pen);
    endfunction

    function automatic logic [BITCNT_W-1:0] dataBits(input logic eight);
        dataBits = BITCNT_W'(NBITS_MIN - 1) + BITCNT_W'(eight);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: counts clk cycles and pulses o_btu on the last cycle of
// an interval of i_target cycles. Shareable between receiver and transmitter.
module uart_bit_timer #(
    parameter int BTC_W = uart_pkg::BTC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic [BTC_W-1:0] i_target,
    output logic             o_btu
);

    logic [BTC_W-1:0] r_btc;
    logic [BTC_W-1:0] w_lastCount;

    assign w_lastCount = i_target - BTC_W'(1);
    assign o_btu       = (r_btc == w_lastCount);

    // Restart on request (state entry) and at every interval boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btc <= '0;
        end else if (i_clear || o_btu) begin
            r_btc <= '0;
        end else begin
            r_btc <= r_btc + BTC_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, bit-centre shift pulses and frame status.
// Define UART_RX_SYNC_EN to pass rx through a 2-flop synchronizer first.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int BTC_W = BTC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic [BTC_W-1:0] k,
    input  logic             eight,
    input  logic             pen,
    input  logic             even,
    input  logic             clr,
    output logic             shift,
    output logic             sdi,
    output logic             rxrdy,
    output logic             perr,
    output logic             ferr,
    output logic             ovf
);

    rx_state_t r_state;
    rx_state_t w_nextState;

    logic w_rxS;
    logic w_btu;
    logic w_timerClear;
    logic w_shift;
    logic w_capture;
    logic w_lastBit;
    logic w_frameDone;

    logic [BTC_W-1:0] w_kClamped;
    logic [BTC_W-1:0] w_target;
    logic [BTC_W-1:0] r_k;
    logic             r_eight;
    logic             r_pen;
    logic             r_even;

    logic [BITCNT_W-1:0] r_bitCnt;
    logic [BITCNT_W-1:0] w_frameBits;
    logic [BITCNT_W-1:0] w_dataBits;
    logic                r_acc;
    logic                r_parBit;

    logic r_rxrdy;
    logic r_perr;
    logic r_ferr;
    logic r_ovf;

`ifdef UART_RX_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Reset high so that reset release never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxS = r_sync2;
`else
    assign w_rxS = rx;
`endif

    // A bit time below 2 would give a zero-length half bit, so it runs as 2.
    assign w_kClamped  = (k < BTC_W'(2)) ? BTC_W'(2) : k;
    assign w_target    = (r_state == RX_START) ? (r_k >> 1) : r_k;
    assign w_frameBits = frameBits(r_eight, r_pen);
    assign w_dataBits  = dataBits(r_eight);
    assign w_lastBit   = (r_bitCnt == (w_frameBits - BITCNT_W'(1)));
    assign w_frameDone = (r_state == RX_DATA) && w_btu && w_lastBit;

    assign w_timerClear = (w_nextState != r_state) ||
                          (r_state == RX_IDLE) || (r_state == RX_BREAK);

    uart_bit_timer #(
        .BTC_W (BTC_W)
    ) u_bitTimer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_timerClear),
        .i_target (w_target),
        .o_btu    (w_btu)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_shift     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (!w_rxS) begin
                    w_nextState = RX_START;
                    w_capture   = 1'b1;
                end
            end
            RX_START: begin
                if (w_btu) begin
                    w_nextState = w_rxS ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_btu) begin
                    w_shift = 1'b1;
                    if (w_lastBit) begin
                        w_nextState = w_rxS ? RX_IDLE : RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (w_rxS) begin
                    w_nextState = RX_IDLE;
                end
            end
            default: begin
                w_nextState = RX_IDLE;
            end
        endcase
    end

    // Frame format is frozen at the start edge so mid-frame changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k     <= BTC_W'(2);
            r_eight <= 1'b0;
            r_pen   <= 1'b0;
            r_even  <= 1'b0;
        end else if (w_capture) begin
            r_k     <= w_kClamped;
            r_eight <= eight;
            r_pen   <= pen;
            r_even  <= even;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bitCnt <= '0;
            r_acc    <= 1'b0;
            r_parBit <= 1'b0;
        end else if ((r_state == RX_START) && (w_nextState == RX_DATA)) begin
            r_bitCnt <= '0;
            r_acc    <= 1'b0;
            r_parBit <= 1'b0;
        end else if (w_shift) begin
            r_bitCnt <= r_bitCnt + BITCNT_W'(1);
            if (r_bitCnt < w_dataBits) begin
                r_acc <= r_acc ^ w_rxS;
            end
            if (r_pen && (r_bitCnt == w_dataBits)) begin
                r_parBit <= w_rxS;
            end
        end
    end

    // A completing frame takes priority over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxrdy <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_frameDone) begin
            r_rxrdy <= 1'b1;
            r_ovf   <= r_ovf | r_rxrdy;
            r_ferr  <= ~w_rxS;
            r_perr  <= r_pen & (r_acc ^ r_parBit ^ ~r_even);
        end else if (clr) begin
            r_rxrdy <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
        end
    end

    assign shift = w_shift;
    assign sdi   = w_rxS;
    assign rxrdy = r_rxrdy;
    assign perr  = r_perr;
    assign ferr  = r_ferr;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: the driver serialises frames and queues the
// expected shift bits and status words; a negedge monitor pops and compares them.
module tb_uart_rx_ctrl;

    localparam int BTC_W = 19;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             rx;
    logic [BTC_W-1:0] k;
    logic             eight;
    logic             pen;
    logic             even;
    logic             clr;
    logic             shift;
    logic             sdi;
    logic             rxrdy;
    logic             perr;
    logic             ferr;
    logic             ovf;

    typedef struct {
        int   cyc;
        logic bitv;
    } shiftExp_t;

    typedef struct {
        int   cyc;
        logic rdy;
        logic pe;
        logic fe;
        logic ov;
    } statExp_t;

    shiftExp_t shiftQ[$];
    statExp_t  statQ[$];

    int   cycleCnt   = 0;
    int   compared   = 0;
    int   mismatched = 0;
    logic mRdy = 1'b0;
    logic mPe  = 1'b0;
    logic mFe  = 1'b0;
    logic mOv  = 1'b0;

    uart_rx_ctrl #(
        .BTC_W (BTC_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .k     (k),
        .eight (eight),
        .pen   (pen),
        .even  (even),
        .clr   (clr),
        .shift (shift),
        .sdi   (sdi),
        .rxrdy (rxrdy),
        .perr  (perr),
        .ferr  (ferr),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    task automatic pushStatus(input int cyc);
        statExp_t st;
        st.cyc = cyc;
        st.rdy = mRdy;
        st.pe  = mPe;
        st.fe  = mFe;
        st.ov  = mOv;
        statQ.push_back(st);
    endtask

    // Monitor: a shift is expected exactly when the queue head names this cycle.
    always @(negedge clk) begin : monitor
        shiftExp_t se;
        statExp_t  st;
        logic      expShift;
        expShift = (shiftQ.size() > 0) && (shiftQ[0].cyc == cycleCnt);
        if ((shift !== 1'b0) || expShift) begin
            checkOutput("shift_pulse", 32'(shift), 32'(expShift));
            if (expShift) begin
                se = shiftQ.pop_front();
                if (shift === 1'b1) begin
                    checkOutput("sdi_bit", 32'(sdi), 32'(se.bitv));
                end
            end
        end
        while ((statQ.size() > 0) && (statQ[0].cyc == cycleCnt)) begin
            st = statQ.pop_front();
            checkOutput("rxrdy", 32'(rxrdy), 32'(st.rdy));
            checkOutput("perr",  32'(perr),  32'(st.pe));
            checkOutput("ferr",  32'(ferr),  32'(st.fe));
            checkOutput("ovf",   32'(ovf),   32'(st.ov));
        end
    end

    task automatic applyClear();
        @(posedge clk); #1;
        clr  = 1'b1;
        mRdy = 1'b0;
        mPe  = 1'b0;
        mFe  = 1'b0;
        mOv  = 1'b0;
        pushStatus(cycleCnt + 1);
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    // Drives one frame; line bit i spans offsets [i*k, (i+1)*k) from the falling edge.
    task automatic applyStimulus(input int kIn, input logic e8, input logic p, input logic ev,
                                 input logic [7:0] data, input logic parBit, input logic stopBit,
                                 input int holdLow, input int gap, input logic clrAtDone,
                                 input int resetAtBit, input logic scramble);
        int          kEff;
        int          h;
        int          nd;
        int          nb;
        int          len;
        int          m;
        int          j;
        int          ones;
        logic [10:0] fbits;
        kEff  = (kIn < 2) ? 2 : kIn;
        h     = kEff / 2;
        nd    = 7 + int'(e8);
        nb    = 8 + int'(e8) + int'(p);
        fbits = '0;
        for (int i = 0; i < nd; i++) fbits[i + 1] = data[i];
        if (p) fbits[nd + 1] = parBit;
        fbits[nb] = stopBit;
        len = (nb + 1) * kEff + holdLow;
        @(posedge clk); #1;
        k     = BTC_W'(kIn);
        eight = e8;
        pen   = p;
        even  = ev;
        for (int o = 0; o < len; o++) begin
            if (o > 0) begin
                @(posedge clk); #1;
            end
            m   = cycleCnt;
            clr = 1'b0;
            rx  = ((o / kEff) <= nb) ? fbits[o / kEff] : 1'b0;
            if (scramble && (o == LAT + 3)) begin
                k     = BTC_W'($urandom_range(60, 2));
                eight = 1'($urandom_range(1, 0));
                pen   = 1'($urandom_range(1, 0));
                even  = 1'($urandom_range(1, 0));
            end
            if ((o >= LAT + h + kEff) && (((o - LAT - h - kEff) % kEff) == 0)) begin
                j = (o - LAT - h - kEff) / kEff;
                if (j < nb) begin
                    shiftQ.push_back('{cyc: m, bitv: fbits[j + 1]});
                    if (j == nb - 1) begin
                        if (clrAtDone) clr = 1'b1;
                        ones = int'(parBit);
                        for (int i = 0; i < nd; i++) ones += int'(data[i]);
                        mOv  = mOv | mRdy;
                        mRdy = 1'b1;
                        mFe  = !stopBit;
                        mPe  = p && ((ones % 2) != (ev ? 0 : 1));
                        pushStatus(m + 1);
                    end
                end
            end
            if ((resetAtBit >= 0) && (o == LAT + resetAtBit * kEff + 2)) begin
                reset = 1'b1;
                rx    = 1'b1;
                mRdy  = 1'b0;
                mPe   = 1'b0;
                mFe   = 1'b0;
                mOv   = 1'b0;
                pushStatus(m);
                @(posedge clk); #1;
                reset = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        clr = 1'b0;
        rx  = 1'b1;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    // A short low pulse must be rejected at the half-bit check without any effect.
    task automatic applyGlitch(input int kIn, input int lowCycles);
        int c;
        @(posedge clk); #1;
        k  = BTC_W'(kIn);
        rx = 1'b0;
        c  = cycleCnt;
        repeat (lowCycles) begin
            @(posedge clk); #1;
        end
        rx = 1'b1;
        pushStatus(c + LAT + kIn / 2 + 2);
        repeat (2 * kIn) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int         kr;
        logic       e8;
        logic       p;
        logic       ev;
        logic [7:0] d;
        logic       pb;
        logic       sb;
        reset = 1'b1;
        rx    = 1'b1;
        clr   = 1'b0;
        k     = BTC_W'(10);
        eight = 1'b1;
        pen   = 1'b0;
        even  = 1'b0;
        @(posedge clk); #1;
        pushStatus(cycleCnt);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end

        $display("[TB] 8N1 0x55, k=10, then glitch");
        applyStimulus(10, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 0, 4, 1'b0, -1, 1'b0);
        applyGlitch(16, 3);
        applyClear();

        $display("[TB] even parity, data 0x07");
        applyStimulus(10, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 0, 3, 1'b0, -1, 1'b0);
        applyClear();
        applyStimulus(10, 1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 1'b1, 0, 3, 1'b0, -1, 1'b0);
        applyClear();

        $display("[TB] 7N1 framing error with held-low line");
        applyStimulus(16, 1'b0, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b0, 100, 3, 1'b0, -1, 1'b0);
        applyClear();

        $display("[TB] back-to-back frames, overrun");
        applyStimulus(10, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 0, 0, 1'b0, -1, 1'b1);
        applyStimulus(10, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 0, 2, 1'b0, -1, 1'b0);
        applyClear();
        applyStimulus(12, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 0, 0, 1'b0, -1, 1'b0);
        applyStimulus(12, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 0, 2, 1'b1, -1, 1'b0);
        applyClear();

        $display("[TB] reset during 4th data bit, then clean frame");
        applyStimulus(10, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 0, 3, 1'b0, 4, 1'b0);
        applyStimulus(10, 1'b1, 1'b1, 1'b0, 8'hA3, 1'b1, 1'b1, 0, 3, 1'b0, -1, 1'b0);
        applyClear();

`ifndef UART_RX_SYNC_EN
        $display("[TB] k=1 runs as k=2");
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 0, 3, 1'b0, -1, 1'b0);
        applyClear();
`endif

        $display("[TB] randomized frames");
        for (int n = 0; n < 24; n++) begin
            kr = int'($urandom_range(40, 8));
            e8 = 1'($urandom_range(1, 0));
            p  = 1'($urandom_range(1, 0));
            ev = 1'($urandom_range(1, 0));
            d  = 8'($urandom);
            pb = 1'($urandom_range(1, 0));
            sb = ($urandom_range(7, 0) != 0);
            applyStimulus(kr, e8, p, ev, d, pb, sb, sb ? 0 : int'($urandom_range(30, 0)),
                          2 + int'($urandom_range(3, 0)), ($urandom_range(4, 0) == 0), -1,
                          1'($urandom_range(1, 0)));
            if ($urandom_range(2, 0) == 0) applyClear();
        end

        repeat (20) begin
            @(posedge clk); #1;
        end
        checkOutput("shift_queue_drained", 32'(shiftQ.size()), 32'd0);
        checkOutput("status_queue_drained", 32'(statQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
